shift_arbiter: RTL and testbench

- Shares one `shift_right` barrel-shifter datapath between two requesters.
  - Typical requesters: ALU issue port and address-generation unit.
- Round-robin arbitration with valid/ready handshakes on both request ports and on the response port.
- Implements SRL, SRA and SLL on the single right-shifter. SLL is done by bit-reversing the operand before the shift and the result after it.
- Results are registered in a one-entry output buffer. Latency is 1 cycle, with full throughput when the consumer is ready.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_right.sv | 18 +
 rtl/shift_unit.sv | 46 ++++
 rtl/shift_arbiter.sv | 104 ++++++++++
 tb/tb_shift_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared shift-op encoding, datapath sizes and bit-reversal helper.
package shift_pkg;

    localparam int unsigned SH_WIDTH = 32;
    localparam int unsigned SH_DEPTH = 5;

    typedef enum logic [1:0] {
        SH_SRL = 2'b00,
        SH_SRA = 2'b01,
        SH_SLL = 2'b10,
        SH_ILL = 2'b11
    } shift_op_t;

    // Reverse bit order so a left shift can run on the right shifter.
    function automatic logic [SH_WIDTH-1:0] bitrev(input logic [SH_WIDTH-1:0] x);
        logic [SH_WIDTH-1:0] r;
        for (int unsigned i = 0; i < SH_WIDTH; i++) begin
            r[i] = x[SH_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_right.sv
// Barrel right shifter; vacated MSBs are filled with c.
module shift_right #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [DEPTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] fill_mask_c;

    // Mask of the bit positions vacated by the shift.
    assign fill_mask_c = ~({WIDTH{1'b1}} >> b);
    assign out         = (a >> b) | (c ? fill_mask_c : '0);

endmodule

// File: rtl/shift_unit.sv
// Combinational SRL/SRA/SLL unit built around one right shifter.
module shift_unit
    import shift_pkg::*;
(
    input  shift_op_t             op_i,
    input  logic [SH_WIDTH-1:0]   a_i,
    input  logic [SH_DEPTH-1:0]   b_i,
    output logic [SH_WIDTH-1:0]   result_o,
    output logic                  err_o
);

    logic [SH_WIDTH-1:0] sh_a;
    logic                sh_c;
    logic [SH_WIDTH-1:0] sh_out;

    shift_right #(
        .WIDTH (SH_WIDTH),
        .DEPTH (SH_DEPTH)
    ) u_shift_right (
        .a   (sh_a),
        .b   (b_i),
        .c   (sh_c),
        .out (sh_out)
    );

    // Select shifter operand, fill bit and result post-processing per op.
    always_comb begin
        sh_a     = a_i;
        sh_c     = 1'b0;
        result_o = sh_out;
        err_o    = 1'b0;
        case (op_i)
            SH_SRL: ;
            SH_SRA: sh_c = a_i[SH_WIDTH-1];
            SH_SLL: begin
                sh_a     = bitrev(a_i);
                result_o = bitrev(sh_out);
            end
            default: begin
                result_o = a_i;
                err_o    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift unit between two requesters,
// with a one-entry registered response buffer.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = SH_WIDTH,
    parameter int unsigned DEPTH = SH_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [3:0]         req_op_i,
    input  logic [2*WIDTH-1:0] req_a_i,
    input  logic [2*DEPTH-1:0] req_b_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [WIDTH-1:0]   rsp_data_o,
    output logic               rsp_err_o
);

    logic             prio_q,      prio_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             rsp_err_q,   rsp_err_d;

    logic             can_acc_c;
    logic             gnt_c;
    logic             gnt_id_c;
    logic [1:0]       sel_op_c;
    logic [WIDTH-1:0] sel_a_c;
    logic [DEPTH-1:0] sel_b_c;
    logic [WIDTH-1:0] result_c;
    logic             err_c;

    // Grant: buffer must be free or draining; prio breaks ties.
    always_comb begin
        can_acc_c = !rsp_valid_q || rsp_ready_i;
        gnt_c     = !rst && can_acc_c && (|req_valid_i);
        gnt_id_c  = (&req_valid_i) ? prio_q : req_valid_i[1];
        req_ready_o = 2'b00;
        if (gnt_c) begin
            req_ready_o[gnt_id_c] = 1'b1;
        end
    end

    // Route the granted requester's operands into the shared unit.
    always_comb begin
        sel_op_c = gnt_id_c ? req_op_i[3:2]          : req_op_i[1:0];
        sel_a_c  = gnt_id_c ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
        sel_b_c  = gnt_id_c ? req_b_i[2*DEPTH-1:DEPTH] : req_b_i[DEPTH-1:0];
    end

    shift_unit u_shift_unit (
        .op_i     (shift_op_t'(sel_op_c)),
        .a_i      (sel_a_c),
        .b_i      (sel_b_c),
        .result_o (result_c),
        .err_o    (err_c)
    );

    // Response buffer and priority next-state.
    always_comb begin
        prio_d      = prio_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (gnt_c) begin
            prio_d      = ~gnt_id_c;
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_id_c;
            rsp_data_d  = result_c;
            rsp_err_d   = err_c;
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [9:0]  req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    shift_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load operands for one requester.
    task automatic drive(input int r, input logic [1:0] op, input logic [31:0] a,
                         input logic [4:0] b);
        if (r == 0) begin
            req_op[1:0] = op; req_a[31:0] = a; req_b[4:0] = b;
        end else begin
            req_op[3:2] = op; req_a[63:32] = a; req_b[9:5] = b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        checks++;
        if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++;
        if ({rsp_id, rsp_err, rsp_data} !== 34'h0) begin
            failures++; $display("FAIL reset_rsp got id=%b err=%b data=%h exp zeros", rsp_id, rsp_err, rsp_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL post_reset_ready got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_ops();
        logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] as  [4] = '{32'h8000_00F0, 32'h8000_00F0, 32'h0000_000F, 32'h1234_5678};
        logic [4:0]  bs  [4] = '{5'd4, 5'd4, 5'd28, 5'd3};
        logic [31:0] exp [4] = '{32'h0800_000F, 32'hF800_000F, 32'hF000_0000, 32'h1234_5678};
        logic        exe [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, ops[i], as[i], bs[i]);
            req_valid = 2'b01;
            #1;
            checks++;
            if (req_ready !== 2'b01) begin failures++; $display("FAIL op%0d_ready got=%b exp=01", i, req_ready); end
            tick();
            req_valid = 2'b00;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== exp[i] || rsp_err !== exe[i]) begin
                failures++;
                $display("FAIL op%0d_result got v=%b id=%b data=%h err=%b exp v=1 id=0 data=%h err=%b",
                         i, rsp_valid, rsp_id, rsp_data, rsp_err, exp[i], exe[i]);
            end
        end
        tick();
    endtask

    task automatic test_round_robin();
        // Single grant to requester 1 leaves prio at 0.
        rsp_ready = 1'b1;
        drive(1, 2'b00, 32'hFFFF_0000, 5'd16);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL r1_ready got=%b exp=10", req_ready); end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'h0000_FFFF) begin
            failures++; $display("FAIL r1_result got v=%b id=%b data=%h exp v=1 id=1 data=0000ffff",
                                 rsp_valid, rsp_id, rsp_data);
        end
        drive(0, 2'b00, 32'h1111_1111, 5'd0);
        drive(1, 2'b00, 32'h2222_2222, 5'd0);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic       eid;
            logic [1:0] erdy;
            eid  = (i % 2 == 1);
            erdy = eid ? 2'b10 : 2'b01;
            #1;
            checks++;
            if (req_ready !== erdy) begin failures++; $display("FAIL rr%0d_ready got=%b exp=%b", i, req_ready, erdy); end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_data !== (eid ? 32'h2222_2222 : 32'h1111_1111)) begin
                failures++; $display("FAIL rr%0d_rsp got v=%b id=%b data=%h exp id=%b", i, rsp_valid, rsp_id, rsp_data, eid);
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_drain();
        // Pending response from requester 1 (0x22222222), no new requests.
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h2222_2222 || rsp_id !== 1'b1) begin
            failures++; $display("FAIL drain got v=%b id=%b data=%h exp v=0 id=1 data=22222222", rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        drive(0, 2'b00, 32'hA5A5_A5A5, 5'd4);
        req_valid = 2'b01;
        tick();
        drive(0, 2'b00, 32'h0000_00F0, 5'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_data !== 32'h0A5A_5A5A || rsp_id !== 1'b0) begin
                failures++; $display("FAIL bp%0d got rdy=%b v=%b id=%b data=%h exp rdy=00 v=1 id=0 data=0a5a5a5a",
                                     i, req_ready, rsp_valid, rsp_id, rsp_data);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_release_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_000F) begin
            failures++; $display("FAIL bp_refill got v=%b data=%h exp v=1 data=0000000f", rsp_valid, rsp_data);
        end
        tick();
    endtask

    task automatic test_boundaries();
        logic [1:0]  ops [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
        logic [31:0] as  [5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000};
        logic [4:0]  bs  [5] = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd31};
        logic [31:0] exp [5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0001};
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, ops[i], as[i], bs[i]);
            req_valid = 2'b10;
            tick();
            req_valid = 2'b00;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== exp[i] || rsp_err !== 1'b0) begin
                failures++; $display("FAIL bound%0d got v=%b id=%b data=%h err=%b exp data=%h",
                                     i, rsp_valid, rsp_id, rsp_data, rsp_err, exp[i]);
            end
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        // Grant to requester 0 moves prio to 1; reset must restore 0.
        rsp_ready = 1'b0;
        drive(0, 2'b00, 32'h0000_0100, 5'd8);
        drive(1, 2'b00, 32'h0000_0200, 5'd8);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b11;
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b exp=1", rsp_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
            failures++; $display("FAIL mid_async got v=%b rdy=%b exp v=0 rdy=00", rsp_valid, req_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_release_ready got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_ops();
        test_round_robin();
        test_drain();
        test_backpressure();
        test_boundaries();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
